// File: rtl/cpu_exec_unit_if.sv
// Command/status bundle between the CPU control FSM (master) and the
// execution unit (slave).
interface cpu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      regEnable;
  logic [7:0]       opcode;
  logic             Aenable;
  logic             Benable;
  logic [3:0]       srcSel;
  logic [WIDTH-1:0] dataIn;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             err;
  logic [WIDTH-1:0] rdData;

  modport master (
    output regEnable, opcode, Aenable, Benable, srcSel, dataIn, start,
    input  busy, done, result, zero, carry, err, rdData
  );

  modport slave (
    input  regEnable, opcode, Aenable, Benable, srcSel, dataIn, start,
    output busy, done, result, zero, carry, err, rdData
  );
endinterface

// File: rtl/cpu_exec_unit.sv
// Execution unit beneath the CPU control FSM: latches operands, runs one ALU
// operation per command and writes the result back to a 16-entry register file.
module cpu_exec_unit #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  cpu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] regs [16];
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] resultReg;
  logic [WIDTH-1:0] aluRes;
  logic [7:0]       opLatched;
  logic [15:0]      enLatched;
  logic             zeroReg;
  logic             carryReg;
  logic             errReg;
  logic             doneReg;
  logic             aluCarry;
  logic             opLegal;
  logic             opActive;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = EXEC;
      EXEC:    nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // opActive marks legal non-NOP opcodes: the only ones that touch flags or registers.
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    opLegal  = 1'b1;
    case (opLatched)
      8'h00: ;
      8'h01: {aluCarry, aluRes} = {1'b0, opA} + {1'b0, opB};
      8'h02: begin
        aluRes   = opA - opB;
        aluCarry = (opA < opB);
      end
      8'h03: aluRes = opA & opB;
      8'h04: aluRes = opA | opB;
      8'h05: aluRes = opA ^ opB;
      8'h06: aluRes = ~opA;
      8'h07: begin
        aluRes   = {opA[WIDTH-2:0], 1'b0};
        aluCarry = opA[WIDTH-1];
      end
      8'h08: begin
        aluRes   = {1'b0, opA[WIDTH-1:1]};
        aluCarry = opA[0];
      end
      8'h09: aluRes = opB;
      8'h0A: aluRes = bus.dataIn;
      default: opLegal = 1'b0;
    endcase
    opActive = opLegal && (opLatched != 8'h00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opA       <= '0;
      opB       <= '0;
      opLatched <= '0;
      enLatched <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b0;
      carryReg  <= 1'b0;
      errReg    <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= (state == WB);
      if (state == IDLE) begin
        if (bus.Aenable) opA <= regs[bus.srcSel];
        if (bus.Benable) opB <= regs[bus.srcSel];
        if (bus.start) begin
          opLatched <= bus.opcode;
          enLatched <= bus.regEnable;
        end
      end
      if (state == EXEC) begin
        if (opActive) begin
          resultReg <= aluRes;
          zeroReg   <= (aluRes == '0);
          carryReg  <= aluCarry;
        end
        if (!opLegal) errReg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (state == WB && opActive) begin
      for (int i = 0; i < 16; i++) begin
        if (enLatched[i]) regs[i] <= resultReg;
      end
    end
  end

  assign bus.busy   = (state == EXEC) || (state == WB);
  assign bus.done   = doneReg;
  assign bus.result = resultReg;
  assign bus.zero   = zeroReg;
  assign bus.carry  = carryReg;
  assign bus.err    = errReg;
  assign bus.rdData = regs[bus.srcSel];

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed testbench for cpu_exec_unit: inputs change and outputs are sampled
// on the falling clock edge.
module tb_cpu_exec_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_exec_unit_if #(.WIDTH(16)) bus ();

  cpu_exec_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idleInputs();
    bus.start = 1'b0; bus.Aenable = 1'b0; bus.Benable = 1'b0;
    bus.opcode = 8'h00; bus.regEnable = 16'h0000; bus.dataIn = 16'h0000; bus.srcSel = 4'h0;
  endtask

  // Issues one command and returns how many falling edges it took for done to show.
  task automatic runCmd(input logic [7:0] op, input logic [15:0] en, input logic [15:0] din,
                        output int cyc);
    @(negedge clk);
    bus.opcode = op; bus.regEnable = en; bus.dataIn = din; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic loadAB(input logic [3:0] selA, input logic [3:0] selB);
    @(negedge clk);
    bus.srcSel = selA; bus.Aenable = 1'b1;
    @(negedge clk);
    bus.Aenable = 1'b0; bus.srcSel = selB; bus.Benable = 1'b1;
    @(negedge clk);
    bus.Benable = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] idx, output logic [15:0] v);
    bus.srcSel = idx;
    #1;
    v = bus.rdData;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    idleInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0000", bus.result); end
    checks++; if ({bus.zero, bus.carry} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {bus.zero, bus.carry}); end
    for (int i = 0; i < 16; i++) begin
      readReg(4'(i), v);
      checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, v); end
    end
  endtask

  task automatic test_load_add();
    int cyc;
    logic [15:0] v;
    runCmd(8'h0A, 16'h0008, 16'h00FF, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL load_latency: got %0d expected 3", cyc); end
    readReg(4'd3, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("[TB] FAIL load_r3: got %h expected 00ff", v); end
    @(negedge clk);
    bus.srcSel = 4'd3; bus.Aenable = 1'b1; bus.Benable = 1'b1;
    @(negedge clk);
    bus.Aenable = 1'b0; bus.Benable = 1'b0;
    runCmd(8'h01, 16'h0020, 16'h0000, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 3", cyc); end
    checks++; if (bus.result !== 16'h01FE) begin errors++; $display("[TB] FAIL add_result: got %h expected 01fe", bus.result); end
    checks++; if ({bus.zero, bus.carry} !== 2'b00) begin errors++; $display("[TB] FAIL add_flags: got %b expected 00", {bus.zero, bus.carry}); end
    readReg(4'd5, v);
    checks++; if (v !== 16'h01FE) begin errors++; $display("[TB] FAIL add_r5: got %h expected 01fe", v); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.opcode = 8'h0A; bus.regEnable = 16'h4000; bus.dataIn = 16'h1357; bus.srcSel = 4'd14; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("[TB] FAIL lat_exec_busy_done: got %b expected 10", {bus.busy, bus.done}); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("[TB] FAIL lat_wb_busy_done: got %b expected 10", {bus.busy, bus.done}); end
    checks++; if (bus.result !== 16'h1357) begin errors++; $display("[TB] FAIL lat_result: got %h expected 1357", bus.result); end
    checks++; if (bus.rdData !== 16'h0000) begin errors++; $display("[TB] FAIL lat_rd_old: got %h expected 0000", bus.rdData); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("[TB] FAIL lat_done_busy_done: got %b expected 01", {bus.busy, bus.done}); end
    checks++; if (bus.rdData !== 16'h1357) begin errors++; $display("[TB] FAIL lat_rd_new: got %h expected 1357", bus.rdData); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL lat_done_fall: got %b expected 0", bus.done); end
  endtask

  task automatic test_flags();
    int cyc;
    logic [15:0] v;
    runCmd(8'h0A, 16'h0002, 16'h8000, cyc);
    loadAB(4'd1, 4'd1);
    runCmd(8'h01, 16'h0000, 16'h0000, cyc);
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL addwrap_result: got %h expected 0000", bus.result); end
    checks++; if ({bus.zero, bus.carry} !== 2'b11) begin errors++; $display("[TB] FAIL addwrap_flags: got %b expected 11", {bus.zero, bus.carry}); end
    readReg(4'd1, v);
    checks++; if (v !== 16'h8000) begin errors++; $display("[TB] FAIL noen_r1: got %h expected 8000", v); end
    runCmd(8'h0A, 16'h0002, 16'h0001, cyc);
    runCmd(8'h0A, 16'h0004, 16'h0002, cyc);
    loadAB(4'd1, 4'd2);
    runCmd(8'h02, 16'h0000, 16'h0000, cyc);
    checks++; if (bus.result !== 16'hFFFF) begin errors++; $display("[TB] FAIL sub_result: got %h expected ffff", bus.result); end
    checks++; if ({bus.zero, bus.carry} !== 2'b01) begin errors++; $display("[TB] FAIL sub_flags: got %b expected 01", {bus.zero, bus.carry}); end
    runCmd(8'h0A, 16'h0002, 16'h8001, cyc);
    loadAB(4'd1, 4'd2);
    runCmd(8'h07, 16'h0000, 16'h0000, cyc);
    checks++; if (bus.result !== 16'h0002) begin errors++; $display("[TB] FAIL shl_result: got %h expected 0002", bus.result); end
    checks++; if ({bus.zero, bus.carry} !== 2'b01) begin errors++; $display("[TB] FAIL shl_flags: got %b expected 01", {bus.zero, bus.carry}); end
    runCmd(8'h08, 16'h0000, 16'h0000, cyc);
    checks++; if (bus.result !== 16'h4000) begin errors++; $display("[TB] FAIL shr_result: got %h expected 4000", bus.result); end
    checks++; if (bus.carry !== 1'b1) begin errors++; $display("[TB] FAIL shr_carry: got %b expected 1", bus.carry); end
    runCmd(8'h05, 16'h0000, 16'h0000, cyc);
    checks++; if (bus.result !== 16'h8003) begin errors++; $display("[TB] FAIL xor_result: got %h expected 8003", bus.result); end
    checks++; if (bus.carry !== 1'b0) begin errors++; $display("[TB] FAIL xor_carry: got %b expected 0", bus.carry); end
    runCmd(8'h00, 16'hFFFF, 16'h0000, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL nop_done: got %0d expected 3", cyc); end
    checks++; if (bus.result !== 16'h8003) begin errors++; $display("[TB] FAIL nop_result: got %h expected 8003", bus.result); end
    readReg(4'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL nop_r0: got %h expected 0000", v); end
  endtask

  task automatic test_illegal();
    int cyc;
    logic [15:0] v;
    runCmd(8'hFF, 16'hFFFF, 16'h0000, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL illegal_done: got %0d expected 3", cyc); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err: got %b expected 1", bus.err); end
    checks++; if (bus.result !== 16'h8003) begin errors++; $display("[TB] FAIL illegal_result: got %h expected 8003", bus.result); end
    readReg(4'd1, v);
    checks++; if (v !== 16'h8001) begin errors++; $display("[TB] FAIL illegal_r1: got %h expected 8001", v); end
    readReg(4'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL illegal_r0: got %h expected 0000", v); end
    runCmd(8'h02, 16'h0100, 16'h0000, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL after_illegal_done: got %0d expected 3", cyc); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", bus.err); end
    readReg(4'd8, v);
    checks++; if (v !== 16'h7FFF) begin errors++; $display("[TB] FAIL after_illegal_r8: got %h expected 7fff", v); end
  endtask

  task automatic test_load_with_start();
    int cyc;
    logic [15:0] v;
    runCmd(8'h0A, 16'h1000, 16'h0005, cyc);
    @(negedge clk);
    bus.srcSel = 4'd12; bus.Aenable = 1'b1; bus.Benable = 1'b1;
    bus.opcode = 8'h01; bus.regEnable = 16'h2000; bus.start = 1'b1;
    @(negedge clk);
    bus.Aenable = 1'b0; bus.Benable = 1'b0; bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL ldstart_done: got %0d expected 3", cyc); end
    readReg(4'd13, v);
    checks++; if (v !== 16'h000A) begin errors++; $display("[TB] FAIL ldstart_r13: got %h expected 000a", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    @(negedge clk);
    bus.opcode = 8'h01; bus.regEnable = 16'h0200; bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", bus.busy); end
    bus.opcode = 8'h02; bus.regEnable = 16'h0400;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %b expected 1", bus.done); end
    readReg(4'd9, v);
    checks++; if (v !== 16'h000A) begin errors++; $display("[TB] FAIL b2b_r9: got %h expected 000a", v); end
    readReg(4'd10, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL ignored_r10: got %h expected 0000", v); end
    bus.regEnable = 16'h0800;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_accept: got %b expected 10", {bus.busy, bus.done}); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_done: got %b expected 0", bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done: got %b expected 1", bus.done); end
    checks++; if ({bus.zero, bus.carry} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_flags: got %b expected 10", {bus.zero, bus.carry}); end
    readReg(4'd11, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_r11: got %h expected 0000", v); end
    readReg(4'd10, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_r10: got %h expected 0000", v); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] v;
    bit sawDone;
    @(negedge clk);
    bus.opcode = 8'h0A; bus.regEnable = 16'h0080; bus.dataIn = 16'h1234; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", bus.busy); end
    rst = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("[TB] FAIL abort_busy_done: got %b expected 00", {bus.busy, bus.done}); end
    @(negedge clk);
    rst = 1'b1;
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %b expected 0", sawDone); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL abort_err_clear: got %b expected 0", bus.err); end
    readReg(4'd7, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL abort_r7: got %h expected 0000", v); end
    readReg(4'd13, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL abort_r13: got %h expected 0000", v); end
  endtask

  task automatic test_multi_write();
    int cyc;
    logic [15:0] v;
    runCmd(8'h0A, 16'h00F0, 16'hA5A5, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL multi_done: got %0d expected 3", cyc); end
    for (int i = 4; i < 8; i++) begin
      readReg(4'(i), v);
      checks++; if (v !== 16'hA5A5) begin errors++; $display("[TB] FAIL multi_r%0d: got %h expected a5a5", i, v); end
    end
    readReg(4'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL multi_r3: got %h expected 0000", v); end
    readReg(4'd8, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("[TB] FAIL multi_r8: got %h expected 0000", v); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_add();
    test_latency();
    test_flags();
    test_illegal();
    test_load_with_start();
    test_back_to_back();
    test_reset_abort();
    test_multi_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
